sha256_msg_padder: RTL and testbench
====================================

Name: sha256_msg_padder

Overview:
- Host-side feeder for the SHA-256 core's 32-bit word-write interface.
- Accepts a message as a byte stream over a valid/ready handshake.
- Applies FIPS 180-4 padding: 0x80 byte, zero fill, 64-bit big-endian bit length.
- Emits 512-bit blocks as 16 big-endian words with first_block/last_block framing, throttled by the core's busy.

Parameters:
LEN_W, 64, width of the internal message bit-length counter; zero-extended to 64 bits in the length field; LEN_W <= 64.

Ports:
clk  input  1  clock; all logic on rising edge
reset  input  1  asynchronous, active-low reset
in_data  input  8  message byte
in_valid  input  1  in_data valid
in_last  input  1  qualifies the final message byte; sampled with in_valid
in_ready  output  1  byte accepted when in_valid & in_ready
busy  input  1  core busy; no word is written while high
data  output  32  word to core, first byte in [31:24]
write_enable  output  1  word transfer strobe
first_block  output  1  marks word 0 of the message's first block; valid only with write_enable
last_block  output  1  marks word 15 of the message's final block; valid only with write_enable
msg_done  output  1  one-cycle pulse, the cycle after the last_block word is written

Behaviour:
- Reset (reset=0, asynchronous): state IDLE, word register empty, byte_idx=0, word_cnt=0, bit length=0.
- Reset output values: data=0, write_enable=0, first_block=0, last_block=0, msg_done=0, in_ready=0.
- in_ready rises the first cycle after reset deasserts.
- Output register: 32-bit word plus a valid flag.
- write_enable = valid & ~busy, combinational from busy. A word transfers in any cycle write_enable=1.
- data, first_block and last_block are held stable while valid & busy.
- word_cnt (0..15) increments per transferred word and wraps 15->0.
- At most one word per cycle. During MSG, at most one byte per cycle.
- in_ready = (state is IDLE or MSG) & !(word register valid & byte_idx==0 pending).
- Packer fills one word while the previous word drains, so input and output overlap.
- Message bytes are packed big-endian. byte_idx 0..3 selects lane [31:24] .. [7:0].
- The bit length increments by 8 per accepted byte and wraps modulo 2^LEN_W.
- States:
  - IDLE: waits for the first byte; accepting it -> MSG, sets first_pending.
  - MSG: packs bytes. On the 4th byte the word loads into the output register (waits if still occupied).
  - On the in_last byte with byte_idx < 3: 0x80 goes in the next lane, zeros in the remaining lanes, the word is loaded -> ZERO.
  - On the in_last byte with byte_idx == 3: the word is loaded -> PAD80.
  - PAD80: emits 0x80000000 -> ZERO.
  - ZERO: emits 0x00000000 until the word about to be emitted has index 14 -> LEN_HI.
  - ZERO spans into a new block when padding started at word 14 or 15.
  - LEN_HI: emits length[63:32] at word 14.
  - LEN_LO: emits length[31:0] at word 15 with last_block=1 -> IDLE; msg_done pulses next cycle.
- Padding entered at word_cnt 14 or 15 forces an extra all-padding block.
- first_block is 1 only on the first transferred word of the message.
- last_block is 1 only on the final word. Intermediate block boundaries carry neither flag.
- Bytes offered while not in_ready are ignored (in_ready low). Zero-length messages are not expressible and not supported.
- A new message may start the cycle after msg_done.
- Reset mid-message: the partial message is discarded, no flags are emitted, and everything restarts from IDLE.
- busy may rise at any cycle, including mid-block. The padder only stalls; it never drops or duplicates a word.

Test Plan:
- "abc" (0x61,0x62,0x63, last on 0x63), busy=0 -> 16 writes:
  - w0=0x61626380 with first_block=1
  - w1..w14=0
  - w15=0x00000018 with last_block=1
  - msg_done pulse one cycle later.
- 55 bytes of 0x00 -> single block, w13=0x00000080, w14=0, w15=0x000001B8, last_block on w15 only.
- 56 bytes of 0x00 -> 32 writes:
  - w14 of block 1 = 0x80000000
  - second block w15=0x000001C0
  - first_block exactly once, last_block exactly once (write 32).
- 64 bytes, last byte at word 15 -> 32 writes:
  - block 2 w0=0x80000000
  - block 2 w15=0x00000200.
- "abc" with busy held high from write 5 for 10 cycles -> write_enable low during the stall, data held, the same 16-word sequence completes.
- Reset pulled low after 30 bytes of a message, then "abc" is sent -> exactly the "abc" sequence with a fresh first_block and no residue.

Source files
------------

// File: rtl/sha256_msg_padder.sv
// rtl/sha256_msg_padder.sv - byte-stream to SHA-256 block feeder with FIPS 180-4 padding
module sha256_msg_padder #(
    parameter int LEN_W = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    input  logic        in_last,
    output logic        in_ready,
    input  logic        busy,
    output logic [31:0] data,
    output logic        write_enable,
    output logic        first_block,
    output logic        last_block,
    output logic        msg_done
);
    typedef enum logic [2:0] {IDLE, MSG, PAD80, ZERO, LEN_HI, LEN_LO} state_t;

    state_t           state_q;
    logic [31:0]      pack_q;
    logic [1:0]       byte_idx_q;
    logic [3:0]       gen_idx_q;
    logic [LEN_W-1:0] len_q;
    logic             first_pend_q;
    logic             ready_en_q;
    logic [31:0]      pw_q;
    logic             pw_valid_q, pw_first_q, pw_last_q;
    logic [31:0]      out_q;
    logic             out_valid_q, out_first_q, out_last_q;
    logic             msg_done_q;

    logic        pw_move, slot_ok, accept, first_now;
    logic [63:0] len64;
    logic [31:0] byte_word, pad_word, gen_word;
    logic        gen_en, gen_last;

    // Two-deep word pipeline: pending word (pw) feeds the output register,
    // so the packer keeps filling while the core drains.
    assign write_enable = out_valid_q & ~busy;
    assign pw_move      = pw_valid_q & (~out_valid_q | write_enable);
    assign slot_ok      = ~pw_valid_q | pw_move;
    assign in_ready     = ready_en_q & ((state_q == IDLE) | (state_q == MSG)) & slot_ok;
    assign accept       = in_valid & in_ready;
    assign first_now    = (state_q == IDLE) | first_pend_q;
    assign len64        = 64'(len_q);

    assign data        = out_q;
    assign first_block = out_first_q;
    assign last_block  = out_last_q;
    assign msg_done    = msg_done_q;

    always_comb begin
        byte_word = pack_q;
        case (byte_idx_q)
            2'd0:    byte_word[31:24] = in_data;
            2'd1:    byte_word[23:16] = in_data;
            2'd2:    byte_word[15:8]  = in_data;
            default: byte_word[7:0]   = in_data;
        endcase
        pad_word = byte_word;
        case (byte_idx_q)
            2'd0:    pad_word[23:16] = 8'h80;
            2'd1:    pad_word[15:8]  = 8'h80;
            2'd2:    pad_word[7:0]   = 8'h80;
            default: pad_word        = byte_word;
        endcase
    end

    always_comb begin
        gen_en   = 1'b0;
        gen_word = 32'h0;
        gen_last = 1'b0;
        case (state_q)
            IDLE, MSG: begin
                gen_en   = accept & (in_last | (byte_idx_q == 2'd3));
                gen_word = (byte_idx_q == 2'd3) ? byte_word : pad_word;
            end
            PAD80: begin
                gen_en   = slot_ok;
                gen_word = 32'h8000_0000;
            end
            ZERO:    gen_en = slot_ok & (gen_idx_q != 4'd14);
            LEN_HI: begin
                gen_en   = slot_ok;
                gen_word = len64[63:32];
            end
            LEN_LO: begin
                gen_en   = slot_ok;
                gen_word = len64[31:0];
                gen_last = 1'b1;
            end
            default: gen_en = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            pack_q       <= 32'h0;
            byte_idx_q   <= 2'd0;
            gen_idx_q    <= 4'd0;
            len_q        <= '0;
            first_pend_q <= 1'b0;
            ready_en_q   <= 1'b0;
            pw_q         <= 32'h0;
            pw_valid_q   <= 1'b0;
            pw_first_q   <= 1'b0;
            pw_last_q    <= 1'b0;
            out_q        <= 32'h0;
            out_valid_q  <= 1'b0;
            out_first_q  <= 1'b0;
            out_last_q   <= 1'b0;
            msg_done_q   <= 1'b0;
        end else begin
            ready_en_q <= 1'b1;
            msg_done_q <= write_enable & out_last_q;
            if (write_enable) out_valid_q <= 1'b0;
            if (pw_move) begin
                out_q       <= pw_q;
                out_first_q <= pw_first_q;
                out_last_q  <= pw_last_q;
                out_valid_q <= 1'b1;
                pw_valid_q  <= 1'b0;
            end
            if (gen_en) begin
                pw_q       <= gen_word;
                pw_first_q <= first_now & ((state_q == IDLE) | (state_q == MSG));
                pw_last_q  <= gen_last;
                pw_valid_q <= 1'b1;
                gen_idx_q  <= gen_idx_q + 4'd1;
            end
            case (state_q)
                IDLE, MSG: if (accept) begin
                    len_q <= (state_q == IDLE) ? LEN_W'(8) : len_q + LEN_W'(8);
                    if (gen_en) begin
                        pack_q       <= 32'h0;
                        byte_idx_q   <= 2'd0;
                        first_pend_q <= 1'b0;
                        if (!in_last)                state_q <= MSG;
                        else if (byte_idx_q == 2'd3) state_q <= PAD80;
                        else                         state_q <= ZERO;
                    end else begin
                        pack_q       <= byte_word;
                        byte_idx_q   <= byte_idx_q + 2'd1;
                        first_pend_q <= first_now;
                        state_q      <= MSG;
                    end
                end
                PAD80:   if (gen_en) state_q <= ZERO;
                ZERO:    if (gen_idx_q == 4'd14) state_q <= LEN_HI;
                LEN_HI:  if (gen_en) state_q <= LEN_LO;
                LEN_LO:  if (gen_en) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sha256_msg_padder.sv
// tb/tb_sha256_msg_padder.sv - directed bench for sha256_msg_padder
module tb_sha256_msg_padder;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  in_data = 8'h0;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic        busy = 1'b0;
    logic        in_ready;
    logic [31:0] data;
    logic        write_enable, first_block, last_block, msg_done;

    sha256_msg_padder #(.LEN_W(64)) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_last(in_last), .in_ready(in_ready), .busy(busy), .data(data),
        .write_enable(write_enable), .first_block(first_block),
        .last_block(last_block), .msg_done(msg_done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    logic [31:0] wq[$];
    bit          fq[$];
    bit          lq[$];
    int last_cyc = -1;
    int done_cyc = -1;
    int done_cnt = 0;

    always @(negedge clk) begin
        cyc++;
        if (write_enable) begin
            wq.push_back(data);
            fq.push_back(first_block);
            lq.push_back(last_block);
            if (last_block) last_cyc = cyc;
        end
        if (msg_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic clear_mon();
        wq.delete();
        fq.delete();
        lq.delete();
        last_cyc = -1;
        done_cyc = -1;
        done_cnt = 0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit last);
        bit got = 0;
        int g = 0;
        @(negedge clk);
        in_data  = b;
        in_valid = 1'b1;
        in_last  = last;
        while (!got) begin
            #1;
            got = in_ready;
            @(posedge clk);
            if (!got) begin
                g++;
                if (g > 300) begin
                    n_cmp++; n_bad++;
                    $display("FAIL send_timeout in_ready stayed 0, required 1");
                    got = 1;
                end else begin
                    @(negedge clk);
                end
            end
        end
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int g = 0;
        while (done_cnt == 0 && g < 600) begin
            @(negedge clk); #1;
            g++;
        end
        repeat (3) begin @(negedge clk); #1; end
        n_cmp++;
        if (done_cnt !== 1 || done_cyc !== last_cyc + 1) begin
            n_bad++;
            $display("FAIL %s_msg_done got count=%0d at=%0d, required count=1 at=%0d",
                     name, done_cnt, done_cyc, last_cyc + 1);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        #1;
        n_cmp++;
        if ({data, write_enable, first_block, last_block, msg_done, in_ready} !== 37'h0) begin
            n_bad++;
            $display("FAIL reset_outputs got data=%h we=%b fb=%b lb=%b md=%b rdy=%b, required all 0",
                     data, write_enable, first_block, last_block, msg_done, in_ready);
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_release_ready got %b, required 0", in_ready);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL ready_after_reset got %b, required 1", in_ready);
        end
    endtask

    task automatic test_abc(input string name);
        logic [31:0] e;
        clear_mon();
        send_byte(8'h61, 0);
        send_byte(8'h62, 0);
        send_byte(8'h63, 1);
        wait_done(name);
        n_cmp++;
        if (wq.size() != 16) begin
            n_bad++;
            $display("FAIL %s_count got %0d writes, required 16", name, wq.size());
        end else begin
            for (int i = 0; i < 16; i++) begin
                e = (i == 0) ? 32'h6162_6380 : (i == 15) ? 32'h0000_0018 : 32'h0;
                n_cmp++;
                if (wq[i] !== e || fq[i] !== (i == 0) || lq[i] !== (i == 15)) begin
                    n_bad++;
                    $display("FAIL %s_w%0d got %h f=%b l=%b, required %h f=%b l=%b",
                             name, i, wq[i], fq[i], lq[i], e, i == 0, i == 15);
                end
            end
        end
    endtask

    task automatic test_55();
        logic [31:0] e;
        clear_mon();
        for (int i = 0; i < 55; i++) send_byte(8'h00, i == 54);
        wait_done("b55");
        n_cmp++;
        if (wq.size() != 16) begin
            n_bad++;
            $display("FAIL b55_count got %0d writes, required 16", wq.size());
        end else begin
            for (int i = 0; i < 16; i++) begin
                e = (i == 13) ? 32'h0000_0080 : (i == 15) ? 32'h0000_01B8 : 32'h0;
                n_cmp++;
                if (wq[i] !== e || fq[i] !== (i == 0) || lq[i] !== (i == 15)) begin
                    n_bad++;
                    $display("FAIL b55_w%0d got %h f=%b l=%b, required %h f=%b l=%b",
                             i, wq[i], fq[i], lq[i], e, i == 0, i == 15);
                end
            end
        end
    endtask

    task automatic test_56();
        logic [31:0] e;
        clear_mon();
        for (int i = 0; i < 56; i++) send_byte(8'h00, i == 55);
        wait_done("b56");
        n_cmp++;
        if (wq.size() != 32) begin
            n_bad++;
            $display("FAIL b56_count got %0d writes, required 32", wq.size());
        end else begin
            for (int i = 0; i < 32; i++) begin
                e = (i == 14) ? 32'h8000_0000 : (i == 31) ? 32'h0000_01C0 : 32'h0;
                n_cmp++;
                if (wq[i] !== e || fq[i] !== (i == 0) || lq[i] !== (i == 31)) begin
                    n_bad++;
                    $display("FAIL b56_w%0d got %h f=%b l=%b, required %h f=%b l=%b",
                             i, wq[i], fq[i], lq[i], e, i == 0, i == 31);
                end
            end
        end
    endtask

    task automatic test_64();
        logic [31:0] e;
        clear_mon();
        for (int i = 0; i < 64; i++) send_byte(8'hFF, i == 63);
        wait_done("b64");
        n_cmp++;
        if (wq.size() != 32) begin
            n_bad++;
            $display("FAIL b64_count got %0d writes, required 32", wq.size());
        end else begin
            for (int i = 0; i < 32; i++) begin
                e = (i < 16) ? 32'hFFFF_FFFF : (i == 16) ? 32'h8000_0000 :
                    (i == 31) ? 32'h0000_0200 : 32'h0;
                n_cmp++;
                if (wq[i] !== e || fq[i] !== (i == 0) || lq[i] !== (i == 31)) begin
                    n_bad++;
                    $display("FAIL b64_w%0d got %h f=%b l=%b, required %h f=%b l=%b",
                             i, wq[i], fq[i], lq[i], e, i == 0, i == 31);
                end
            end
        end
    endtask

    task automatic test_stall();
        logic [31:0] held;
        logic [31:0] e;
        int g = 0;
        clear_mon();
        send_byte(8'h61, 0);
        send_byte(8'h62, 0);
        send_byte(8'h63, 1);
        while (wq.size() < 5 && g < 200) begin
            @(negedge clk); #1;
            g++;
        end
        n_cmp++;
        if (wq.size() != 5) begin
            n_bad++;
            $display("FAIL stall_reach_w5 got %0d writes, required 5", wq.size());
        end
        @(posedge clk); #1;
        busy = 1'b1;
        @(negedge clk); #1;
        held = data;
        n_cmp++;
        if (held !== 32'h0) begin
            n_bad++;
            $display("FAIL stall_w5_data got %h, required 00000000", held);
        end
        repeat (9) begin
            n_cmp++;
            if (write_enable !== 1'b0 || data !== held) begin
                n_bad++;
                $display("FAIL stall_hold got we=%b data=%h, required we=0 data=%h",
                         write_enable, data, held);
            end
            @(negedge clk); #1;
        end
        n_cmp++;
        if (wq.size() != 5) begin
            n_bad++;
            $display("FAIL stall_no_write got %0d writes, required 5", wq.size());
        end
        @(posedge clk); #1;
        busy = 1'b0;
        wait_done("stall");
        n_cmp++;
        if (wq.size() != 16) begin
            n_bad++;
            $display("FAIL stall_count got %0d writes, required 16", wq.size());
        end else begin
            for (int i = 0; i < 16; i++) begin
                e = (i == 0) ? 32'h6162_6380 : (i == 15) ? 32'h0000_0018 : 32'h0;
                n_cmp++;
                if (wq[i] !== e || fq[i] !== (i == 0) || lq[i] !== (i == 15)) begin
                    n_bad++;
                    $display("FAIL stall_w%0d got %h f=%b l=%b, required %h f=%b l=%b",
                             i, wq[i], fq[i], lq[i], e, i == 0, i == 15);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 30; i++) send_byte(8'(i + 1), 0);
        repeat (2) @(negedge clk);
        #1;
        reset = 1'b0;
        #1;
        n_cmp++;
        if ({data, write_enable, first_block, last_block, msg_done, in_ready} !== 37'h0) begin
            n_bad++;
            $display("FAIL midreset_outputs got data=%h we=%b fb=%b lb=%b md=%b rdy=%b, required all 0",
                     data, write_enable, first_block, last_block, msg_done, in_ready);
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL midreset_ready got %b, required 1", in_ready);
        end
        test_abc("after_reset");
    endtask

    initial begin
        test_reset();
        test_abc("abc");
        test_55();
        test_56();
        test_64();
        test_stall();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
